// File: rtl/cordic_gain_comp.sv
// cordic_gain_comp: CORDIC gain compensation, round half-up, fold-back negation, 2-stage valid/ready pipe.
// Define CORDIC_GAIN_SAT_EN to saturate on range-limit; otherwise results wrap to WIDTH bits.
module cordic_gain_comp #(
  parameter int WIDTH = 16,
  parameter int FRAC = 14,
  parameter logic signed [WIDTH-1:0] K_GAIN = 16'h26DD
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic signed [WIDTH-1:0] i_x,
  input  logic signed [WIDTH-1:0] i_y,
  input  logic signed [WIDTH-1:0] i_z,
  input  logic                    i_neg,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic signed [WIDTH-1:0] o_x,
  output logic signed [WIDTH-1:0] o_y,
  output logic signed [WIDTH-1:0] o_z
);
  localparam int PW = 2 * WIDTH;
  localparam logic signed [PW:0] RND = (PW+1)'(1) <<< (FRAC - 1);
  localparam logic signed [PW:0] MAXV = ((PW+1)'(1) <<< (WIDTH - 1)) - (PW+1)'(1);
  localparam logic signed [PW:0] MINV = -MAXV - (PW+1)'(1);
  logic signed [PW-1:0] px_q, py_q, px_d, py_d;
  logic signed [WIDTH-1:0] z1_q, ox_q, oy_q, oz_q, ox_d, oy_d;
  logic neg1_q, v1_q, v2_q, s1_adv, s2_adv;
  function automatic logic signed [WIDTH-1:0] lim(input logic signed [PW:0] v);
`ifdef CORDIC_GAIN_SAT_EN
    lim = v > MAXV ? WIDTH'(MAXV) : v < MINV ? WIDTH'(MINV) : WIDTH'(v);
`else
    lim = WIDTH'(v);
`endif
  endfunction
  // Range-limit once after rounding and again after the fold-back negation.
  function automatic logic signed [WIDTH-1:0] comp(input logic signed [PW-1:0] p, input logic n);
    logic signed [PW:0] r;
    logic signed [WIDTH-1:0] a;
    r = ((PW+1)'(p) + RND) >>> FRAC;
    a = lim(r);
    comp = n ? lim(-(PW+1)'(a)) : a;
  endfunction
  assign s2_adv  = ~v2_q | i_ready;
  assign s1_adv  = ~v1_q | s2_adv;
  assign o_ready = s1_adv;
  assign px_d    = PW'(i_x) * PW'(K_GAIN);
  assign py_d    = PW'(i_y) * PW'(K_GAIN);
  assign ox_d    = comp(px_q, neg1_q);
  assign oy_d    = comp(py_q, neg1_q);
  assign o_valid = v2_q;
  assign o_x     = ox_q;
  assign o_y     = oy_q;
  assign o_z     = oz_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      px_q   <= '0;
      py_q   <= '0;
      z1_q   <= '0;
      neg1_q <= 1'b0;
      v1_q   <= 1'b0;
      ox_q   <= '0;
      oy_q   <= '0;
      oz_q   <= '0;
      v2_q   <= 1'b0;
    end else begin
      if (s1_adv) begin
        px_q   <= px_d;
        py_q   <= py_d;
        z1_q   <= i_z;
        neg1_q <= i_neg;
        v1_q   <= i_valid;
      end
      if (s2_adv) begin
        ox_q <= ox_d;
        oy_q <= oy_d;
        oz_q <= z1_q;
        v2_q <= v1_q;
      end
    end
  end
endmodule

// File: tb/tb_cordic_gain_comp.sv
// tb_cordic_gain_comp: random and directed stimulus against a queue-based arithmetic model.
// Two instances share inputs: default K and K=16'h7FFF to reach the range-limit paths.
module tb_cordic_gain_comp;
  logic i_clk = 1'b0, i_rst_n = 1'b0, i_valid = 1'b0, i_ready = 1'b1, i_neg = 1'b0;
  logic signed [15:0] i_x = '0, i_y = '0, i_z = '0;
  logic o_ready, o_ready_b, o_valid_a, o_valid_b;
  logic signed [15:0] o_x_a, o_y_a, o_z_a, o_x_b, o_y_b, o_z_b;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic acc = 1'b0, hold = 1'b0;
  logic signed [15:0] hx, hy, hz;
  typedef struct { logic signed [15:0] xa, ya, xb, yb, z; int t; } exp_t;
  exp_t q[$];

  cordic_gain_comp dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_x(i_x), .i_y(i_y), .i_z(i_z), .i_neg(i_neg), .o_valid(o_valid_a),
    .i_ready(i_ready), .o_x(o_x_a), .o_y(o_y_a), .o_z(o_z_a)
  );
  cordic_gain_comp #(.K_GAIN(16'h7FFF)) dut_k (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready_b),
    .i_x(i_x), .i_y(i_y), .i_z(i_z), .i_neg(i_neg), .o_valid(o_valid_b),
    .i_ready(i_ready), .o_x(o_x_b), .o_y(o_y_b), .o_z(o_z_b)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint lim(input longint r);
    logic signed [15:0] t;
`ifdef CORDIC_GAIN_SAT_EN
    return r > 32767 ? 32767 : r < -32768 ? -32768 : r;
`else
    t = 16'(r);
    return longint'(t);
`endif
  endfunction

  function automatic logic signed [15:0] model(input longint v, input longint k, input bit n);
    longint r;
    r = lim((v * k + 8192) >>> 14);
    if (n) r = lim(-r);
    return 16'(r);
  endfunction

  function automatic logic signed [15:0] rnd();
    int unsigned r;
    r = $urandom % 8;
    return r == 0 ? 16'sh8000 : r == 1 ? 16'sh7FFF : 16'($urandom);
  endfunction

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      hold = 1'b0;
      acc = 1'b0;
    end else begin
      cyc++;
      chk("ready", o_ready, q.size() < 2 || i_ready);
      chk("ready_b", o_ready_b, q.size() < 2 || i_ready);
      chk("valid", o_valid_a, q.size() > 0 && cyc - q[0].t >= 2);
      chk("valid_b", o_valid_b, q.size() > 0 && cyc - q[0].t >= 2);
      if (hold) begin
        chk("stall_x", o_x_a, hx);
        chk("stall_y", o_y_a, hy);
        chk("stall_z", o_z_a, hz);
      end
      hold = o_valid_a && !i_ready;
      hx = o_x_a; hy = o_y_a; hz = o_z_a;
      acc = i_valid && o_ready;
      if (o_valid_a && i_ready && q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("x", o_x_a, e.xa);
        chk("y", o_y_a, e.ya);
        chk("z", o_z_a, e.z);
        chk("x_k", o_x_b, e.xb);
        chk("y_k", o_y_b, e.yb);
        chk("z_k", o_z_b, e.z);
      end
      if (acc)
        q.push_back('{model(i_x, 9949, i_neg), model(i_y, 9949, i_neg),
                      model(i_x, 32767, i_neg), model(i_y, 32767, i_neg), i_z, cyc});
    end
  end

  // Drive one beat into an empty pipe and stop at the negedge where it is presented.
  task automatic send_one(input logic signed [15:0] x, y, z, input logic n);
    i_x = x; i_y = y; i_z = z; i_neg = n; i_valid = 1'b1; i_ready = 1'b1;
    @(posedge i_clk); #1 i_valid = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  initial begin
    #3;
    chk("rst_valid", o_valid_a, 0);
    chk("rst_x", o_x_a, 0);
    chk("rst_z", o_z_a, 0);
    chk("rst_ready", o_ready, 1);
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    send_one(16384, -16384, 1234, 1'b0);
    chk("basic_x", o_x_a, 9949);
    chk("basic_y", o_y_a, -9949);
    chk("basic_z", o_z_a, 1234);
    @(negedge i_clk) chk("basic_pulse", o_valid_a, 0);
    @(posedge i_clk); #1;
    send_one(16384, 8192, -77, 1'b1);
    chk("neg_x", o_x_a, -9949);
    chk("neg_y", o_y_a, -4975);
    chk("neg_z", o_z_a, -77);
    @(posedge i_clk); #1;
    send_one(32767, -32768, 5, 1'b0);
`ifdef CORDIC_GAIN_SAT_EN
    chk("sat_x", o_x_b, 32767);
    chk("sat_y", o_y_b, -32768);
`else
    chk("sat_x", o_x_b, -4);
    chk("sat_y", o_y_b, 2);
`endif
    @(posedge i_clk); #1;
    send_one(-32768, 0, 6, 1'b1);
`ifdef CORDIC_GAIN_SAT_EN
    chk("negfs_x", o_x_b, 32767);
`else
    chk("negfs_x", o_x_b, -2);
`endif
    // Back-pressure: 8 beats with the consumer stalled for cycles 3-6.
    @(posedge i_clk); #1;
    begin
      int sent;
      sent = 0;
      for (int c = 0; c < 40; c++) begin
        i_ready = !(c >= 3 && c <= 6);
        if (!i_valid || acc) begin
          i_valid = sent < 8;
          i_x = 16'(100 * sent + 1); i_y = 16'(-50 * sent); i_z = 16'(sent); i_neg = sent[0];
          if (sent < 8) sent++;
        end
        @(posedge i_clk); #1;
      end
      i_valid = 1'b0;
    end
    chk("bp_drain", q.size(), 0);
    // Randomized traffic with random consumer stalls, then a clean drain.
    for (int c = 0; c < 340; c++) begin
      if (!i_valid || acc) begin
        i_valid = c < 300 && ($urandom % 4 != 0);
        i_x = rnd(); i_y = rnd(); i_z = rnd(); i_neg = 1'($urandom);
      end
      i_ready = c >= 300 || ($urandom % 3 != 0);
      @(posedge i_clk); #1;
    end
    chk("rand_drain", q.size(), 0);
    // Reset with both stages full.
    i_ready = 1'b0; i_valid = 1'b1; i_x = 1000; i_y = 2000; i_z = 3000; i_neg = 1'b0;
    for (int c = 0; c < 10 && q.size() < 2; c++) begin
      @(posedge i_clk); #1;
    end
    chk("full_before_rst", q.size(), 2);
    #1 i_rst_n = 1'b0;
    #1;
    chk("arst_valid", o_valid_a, 0);
    chk("arst_x", o_x_a, 0);
    chk("arst_z", o_z_a, 0);
    chk("arst_ready", o_ready, 1);
    q.delete();
    i_valid = 1'b0;
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    send_one(-16384, 16384, 42, 1'b0);
    chk("post_rst_valid", o_valid_a, 1);
    chk("post_rst_x", o_x_a, -9949);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    chk("final_drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end
endmodule
